// File: rtl/mem_access_unit.sv
// Load/store stage: runs one data-memory transaction per accepted request over a
// req/ack handshake and returns a formatted load result or store completion.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        done,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0]  F3_B   = 3'b000;
    localparam logic [2:0]  F3_H   = 3'b001;
    localparam logic [2:0]  F3_W   = 3'b010;
    localparam logic [2:0]  F3_BU  = 3'b100;
    localparam logic [2:0]  F3_HU  = 3'b101;
    localparam logic [1:0]  ERR_NONE  = 2'b00;
    localparam logic [1:0]  ERR_ALIGN = 2'b01;
    localparam logic [1:0]  ERR_TMO   = 2'b10;
    localparam logic [1:0]  ERR_ILL   = 2'b11;
    localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 32'd1);

    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: calc_be = 4'b0001 << a;
            F3_H, F3_HU: calc_be = a[1] ? 4'b1100 : 4'b0011;
            F3_W:        calc_be = 4'b1111;
            default:     calc_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    calc_wdata = {4{d[7:0]}};
            F3_H:    calc_wdata = {2{d[15:0]}};
            F3_W:    calc_wdata = d;
            default: calc_wdata = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rdata);
        logic [31:0] lane;
        lane = rdata >> {a, 3'b000};
        case (f3)
            F3_B:    fmt_load = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   fmt_load = {24'h00_0000, lane[7:0]};
            F3_H:    fmt_load = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   fmt_load = {16'h0000, lane[15:0]};
            F3_W:    fmt_load = lane;
            default: fmt_load = 32'h0000_0000;
        endcase
    endfunction

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [2:0]  f3_r, f3_s;
    logic [1:0]  alo_r, alo_s;
    logic [4:0]  rd_r, rd_s;
    logic        load_r, load_s;
    logic        ready_r, ready_s;
    logic        req_s, we_s, done_s, wb_we_s;
    logic [31:0] daddr_s, wdata_s, wb_data_s;
    logic [3:0]  be_s;
    logic [4:0]  wb_rd_s;
    logic [1:0]  err_s;
    logic        illegal_s, misalign_s;

    assign ready_in = ready_r;

    // Request classification; illegal encodings are checked ahead of alignment.
    always_comb begin
        illegal_s  = (is_load == is_store) ||
                     (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                     (is_store && ((funct3 == F3_BU) || (funct3 == F3_HU)));
        misalign_s = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                     ((funct3 == F3_W) && (addr[1:0] != 2'b00));
    end

    // Next-state and next-output computation for every registered output.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        f3_s      = f3_r;
        alo_s     = alo_r;
        rd_s      = rd_r;
        load_s    = load_r;
        req_s     = dmem_req;
        we_s      = dmem_we;
        daddr_s   = dmem_addr;
        be_s      = dmem_be;
        wdata_s   = dmem_wdata;
        done_s    = 1'b0;
        wb_we_s   = 1'b0;
        wb_rd_s   = wb_rd;
        wb_data_s = wb_data;
        err_s     = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (valid_in) begin
                    f3_s   = funct3;
                    alo_s  = addr[1:0];
                    rd_s   = rd_in;
                    load_s = is_load;
                    if (illegal_s || misalign_s) begin
                        state_s   = ST_RESP;
                        done_s    = 1'b1;
                        err_s     = illegal_s ? ERR_ILL : ERR_ALIGN;
                        wb_rd_s   = rd_in;
                        wb_data_s = 32'h0000_0000;
                    end else begin
                        state_s = ST_REQ;
                        cnt_s   = 16'h0000;
                        req_s   = 1'b1;
                        we_s    = is_store;
                        daddr_s = {addr[31:2], 2'b00};
                        be_s    = calc_be(funct3, addr[1:0]);
                        wdata_s = is_store ? calc_wdata(funct3, store_data) : 32'h0000_0000;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_ack || (cnt_r == CNT_LAST)) begin
                    // Ack takes precedence over a timeout in the same cycle.
                    state_s   = ST_RESP;
                    done_s    = 1'b1;
                    err_s     = dmem_ack ? ERR_NONE : ERR_TMO;
                    wb_rd_s   = rd_r;
                    wb_data_s = (dmem_ack && load_r) ? fmt_load(f3_r, alo_r, dmem_rdata)
                                                     : 32'h0000_0000;
                    wb_we_s   = dmem_ack && load_r && (rd_r != 5'd0);
                    req_s     = 1'b0;
                    we_s      = 1'b0;
                    daddr_s   = 32'h0000_0000;
                    be_s      = 4'b0000;
                    wdata_s   = 32'h0000_0000;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
                we_s    = 1'b0;
            end
        endcase
        ready_s = (state_s == ST_IDLE);
    end

    // State, context and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 16'h0000;
            f3_r       <= 3'b000;
            alo_r      <= 2'b00;
            rd_r       <= 5'd0;
            load_r     <= 1'b0;
            ready_r    <= 1'b1;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0000_0000;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0000_0000;
            done       <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'h0000_0000;
            err        <= 2'b00;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            f3_r       <= f3_s;
            alo_r      <= alo_s;
            rd_r       <= rd_s;
            load_r     <= load_s;
            ready_r    <= ready_s;
            dmem_req   <= req_s;
            dmem_we    <= we_s;
            dmem_addr  <= daddr_s;
            dmem_be    <= be_s;
            dmem_wdata <= wdata_s;
            done       <= done_s;
            wb_we      <= wb_we_s;
            wb_rd      <= wb_rd_s;
            wb_data    <= wb_data_s;
            err        <= err_s;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a short timeout of 4 cycles.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        done;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .rd_in(rd_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .done(done), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request; ack in 0-based REQ cycle ack_at (negative = never). Ends back in IDLE.
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                           input int ack_at, input logic [31:0] rdat,
                           output int req_cyc, output int lat,
                           output logic [3:0] be_o, output logic [31:0] addr_o,
                           output logic [31:0] wdata_o, output logic we_o,
                           output logic got_done, output logic wbwe_o,
                           output logic [31:0] wbd_o, output logic [4:0] wbrd_o,
                           output logic [1:0] err_o);
        valid_in = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        addr = a; store_data = sd; rd_in = rd;
        step();
        valid_in = 1'b0;
        req_cyc = 0; lat = 1; got_done = 1'b0;
        be_o = 4'h0; addr_o = 32'h0; wdata_o = 32'h0; we_o = 1'b0;
        wbwe_o = 1'b0; wbd_o = 32'h0; wbrd_o = 5'd0; err_o = 2'b00;
        while (!got_done && lat < 20) begin
            if (done) begin
                got_done = 1'b1;
                wbwe_o = wb_we; wbd_o = wb_data; wbrd_o = wb_rd; err_o = err;
            end else begin
                if (dmem_req) begin
                    if (req_cyc == 0) begin
                        be_o = dmem_be; addr_o = dmem_addr; wdata_o = dmem_wdata; we_o = dmem_we;
                    end
                    dmem_ack   = (req_cyc == ack_at);
                    dmem_rdata = rdat;
                    req_cyc++;
                end
                step();
                dmem_ack = 1'b0;
                lat++;
            end
        end
        step();
    endtask

    int          rc, lt;
    logic [3:0]  be_c;
    logic [31:0] ad_c, wd_c, wbd_c;
    logic        we_c, dn_c, wbwe_c;
    logic [4:0]  wbrd_c;
    logic [1:0]  err_c;

    initial begin
        rst = 1'b1; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; rd_in = 5'd0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        step(); step();
        check("rst_ready", ready_in, 1);
        check("rst_req", dmem_req, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_wbdata", wb_data, 0);
        rst = 1'b0;
        step();

        // LB sign-extension, zero-wait ack; DUT outputs checked in first REQ cycle.
        valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0000_1003; rd_in = 5'd5;
        step();
        valid_in = 1'b0;
        check("lb_req", dmem_req, 1);
        check("lb_be", dmem_be, 4'b1000);
        check("lb_addr", dmem_addr, 32'h0000_1000);
        check("lb_ready_low", ready_in, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234;
        step();
        dmem_ack = 1'b0;
        check("lb_done", done, 1);
        check("lb_wbwe", wb_we, 1);
        check("lb_data", wb_data, 32'hFFFF_FF80);
        check("lb_rd", wb_rd, 5);
        check("lb_req_drop", dmem_req, 0);
        step();
        check("lb_done_clr", done, 0);
        check("lb_ready_back", ready_in, 1);

        run_txn(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd6, 0, 32'h80FF_1234,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("lbu_data", wbd_c, 32'h0000_0080);
        check("lbu_lat", lt, 2);

        run_txn(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 5'd7, 0, 32'h8001_7FFF,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("lh_data", wbd_c, 32'hFFFF_8001);
        check("lh_be", be_c, 4'b0011 << 2);

        run_txn(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd3, 3, 32'h0,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("sh_reqcyc", rc, 4);
        check("sh_be", be_c, 4'b1100);
        check("sh_wdata", wd_c, 32'hABCD_ABCD);
        check("sh_we", we_c, 1);
        check("sh_addr", ad_c, 32'h0000_2000);
        check("sh_done", dn_c, 1);
        check("sh_wbwe", wbwe_c, 0);
        check("sh_err", err_c, 0);

        run_txn(1'b0, 1'b1, 3'b000, 32'h0000_0031, 32'h0000_005A, 5'd1, 0, 32'h0,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("sb_be", be_c, 4'b0010);
        check("sb_wdata", wd_c, 32'h5A5A_5A5A);

        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd9, 0, 32'h1111_1111,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("mis_reqcyc", rc, 0);
        check("mis_lat", lt, 1);
        check("mis_err", err_c, 2'b01);
        check("mis_wbdata", wbd_c, 0);
        check("mis_wbwe", wbwe_c, 0);

        run_txn(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd9, 0, 32'h0,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("ill_f3_err", err_c, 2'b11);
        check("ill_f3_req", rc, 0);

        run_txn(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0, 5'd9, 0, 32'h0,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("ill_sbu_err", err_c, 2'b11);

        run_txn(1'b1, 1'b1, 3'b001, 32'h0000_0001, 32'h0, 5'd9, 0, 32'h0,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("ill_prio_err", err_c, 2'b11);

        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd4, -1, 32'h0,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("tmo_reqcyc", rc, 4);
        check("tmo_err", err_c, 2'b10);
        check("tmo_done", dn_c, 1);
        check("tmo_wbwe", wbwe_c, 0);

        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd4, 3, 32'hDEAD_BEEF,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("tmo_ack_reqcyc", rc, 4);
        check("tmo_ack_err", err_c, 2'b00);
        check("tmo_ack_data", wbd_c, 32'hDEAD_BEEF);
        check("tmo_ack_wbwe", wbwe_c, 1);

        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd0, 0, 32'h1234_5678,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("x0_wbwe", wbwe_c, 0);

        // Reset in the second REQ cycle, then a stale ack.
        valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
        addr = 32'h0000_0200; rd_in = 5'd8;
        step();
        valid_in = 1'b0;
        check("mid_req1", dmem_req, 1);
        step();
        check("mid_req2", dmem_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_req_drop", dmem_req, 0);
        check("mid_ready", ready_in, 1);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        step();
        dmem_ack = 1'b0;
        check("stale_done1", done, 0);
        step();
        check("stale_done2", done, 0);

        run_txn(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344, 5'd2, 0, 32'h0,
                rc, lt, be_c, ad_c, wd_c, we_c, dn_c, wbwe_c, wbd_c, wbrd_c, err_c);
        check("sw_be", be_c, 4'b1111);
        check("sw_wdata", wd_c, 32'h1122_3344);
        check("sw_done", dn_c, 1);
        check("sw_err", err_c, 0);
        check("sw_lat", lt, 2);

        // Back-to-back loads with valid_in held high.
        begin
            int acc, ndone, prev, rdy_bad;
            acc = 0; ndone = 0; prev = 0; rdy_bad = 0;
            is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
            for (int c = 0; c < 15; c++) begin
                if (done) begin
                    check("b2b_rd", wb_rd, ndone + 1);
                    check("b2b_data", wb_data, 32'hA000_0000 + ndone);
                    ndone++;
                end
                if (ready_in && (dmem_req || done)) rdy_bad++;
                dmem_ack   = dmem_req;
                dmem_rdata = 32'hA000_0000 + (acc - 1);
                if (ready_in) begin
                    if (acc < 3) begin
                        valid_in = 1'b1;
                        addr     = 32'h0000_0040 + 32'(4 * acc);
                        rd_in    = 5'(acc + 1);
                        if (acc > 0) check("b2b_gap", c - prev, 3);
                        prev = c;
                        acc++;
                    end else begin
                        valid_in = 1'b0;
                    end
                end
                step();
            end
            valid_in = 1'b0; dmem_ack = 1'b0;
            check("b2b_ndone", ndone, 3);
            check("b2b_ready", rdy_bad, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the ALU.
- Takes the ALU result as the effective address and the rs2 value as store data.
- Runs one data-memory transaction over a req/ack handshake.
- Returns a sign- or zero-extended load result, or a store completion, to write-back.
- Multi-cycle: the FSM stalls upstream through ready_in until memory acknowledges or a timeout fires.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles dmem_req may stay high without dmem_ack before the access aborts with a bus error. Legal range is 2..65535.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  request from execute
- ready_in  output  1  unit can accept a request (high only in IDLE)
- is_load  input  1  request is a load
- is_store  input  1  request is a store
- funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  effective address (ALU result)
- store_data  input  32  rs2 value
- rd_in  input  5  destination register
- dmem_req  output  1  memory request, held until ack or abort
- dmem_we  output  1  write enable
- dmem_addr  output  32  word address {addr[31:2],2'b00}
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-aligned write data
- dmem_ack  input  1  memory done; dmem_rdata valid in the same cycle
- dmem_rdata  input  32  read word
- done  output  1  one-cycle completion pulse
- wb_we  output  1  write-back enable (loads with err=00 only)
- wb_rd  output  5  destination register
- wb_data  output  32  formatted load data; 0 for stores and errors
- err  output  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal

Behaviour:
- Reset: state=IDLE, counter=0. All registered outputs are 0 (dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, done, wb_we, wb_rd, wb_data, err). ready_in=1 in the cycle after reset.
- Reset mid-transaction drops dmem_req on the next edge and discards the access. An ack arriving in IDLE is ignored.
- States: IDLE, REQ, RESP.
- Accept: valid_in && ready_in at an edge latches funct3, addr, store_data and rd_in.
- Illegal request: any of the following goes to RESP with err=11 and no dmem_req:
  - is_load==is_store;
  - funct3 in {011,110,111};
  - store with funct3 in {100,101}.
- Misaligned request: H/HU with addr[0]=1, or W with addr[1:0]!=0, goes to RESP with err=01 and no dmem_req. Illegal takes priority over misaligned.
- Otherwise go to REQ. Counter clears to 0, and dmem_req/we/addr/be/wdata are registered, so dmem_req is high in the first REQ cycle.
- Byte enables (loads and stores):
  - B/BU: be = 4'b0001 << addr[1:0]
  - H/HU: be = addr[1] ? 1100 : 0011
  - W: be = 1111
- Write data:
  - SB: wdata = {4{store_data[7:0]}}
  - SH: wdata = {2{store_data[15:0]}}
  - SW: wdata = store_data
  - loads: wdata = 0 and dmem_we = 0
- REQ: dmem_* outputs are held stable every cycle until exit.
  - dmem_ack=1: next edge goes to RESP. The load result is formatted from dmem_rdata and dmem_req drops.
  - No ack: counter increments. If the counter equals TIMEOUT_CYCLES-1 and no ack is present, the next edge goes to RESP with err=10 and dmem_req drops. So dmem_req is high for exactly TIMEOUT_CYCLES cycles.
  - Ack in the timeout cycle: ack wins, err=00.
- Load formatting: lane = dmem_rdata >> (8*addr[1:0]).
  - LB: sign-extend lane[7:0]
  - LBU: zero-extend lane[7:0]
  - LH: sign-extend lane[15:0]
  - LHU: zero-extend lane[15:0]
  - LW: the full word
- RESP lasts exactly one cycle:
  - done=1, err as latched, wb_rd=latched rd.
  - wb_we=1 only for a load with err=00 and rd!=0.
  - The next state is IDLE.
  - ready_in=0 in RESP. done, wb_we and err return to 0 in the following cycle; wb_data/wb_rd may hold.
- Throughput: a successful access completes at minimum 3 cycles after accept with a zero-wait ack (accept edge, REQ, RESP). An error completes 2 cycles after accept.

Test Plan:
- LB at addr 0x1003, dmem_rdata=0x80FF_1234, ack in the first REQ cycle → dmem_be=1000, dmem_addr=0x1000; next cycle done=1, wb_we=1, wb_data=0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH of 0x1234_ABCD at addr 0x2002, ack after 3 wait cycles → dmem_req high for 4 cycles, be=1100, wdata=0xABCD_ABCD, we=1; done=1, wb_we=0, err=00.
- LW at addr 0x0006 → no dmem_req ever asserted; done=1 with err=01 two cycles after accept, wb_data=0. funct3=011 → err=11.
- Timeout: TIMEOUT_CYCLES=4, LW to 0x100 with no ack → dmem_req high exactly 4 cycles, then done=1, err=10. Repeat with ack in the 4th cycle → err=00 and load data returned.
- Reset asserted in the 2nd REQ cycle → next cycle dmem_req=0 and ready_in=1. A stale ack afterwards produces no done pulse, and a fresh SW completes normally.
- Back-to-back: assert valid_in continuously with 3 loads and zero-wait acks → one accept per 3 cycles, ready_in low during REQ/RESP, three done pulses with correct rd tags.
